add_operand_loader: RTL

Upstream operand stage for the 32-bit ripple adder. It receives operands as 8-bit beats over a valid/ready byte stream and assembles two 32-bit operands plus a carry-in. It then presents them to the adder's in1/in2/cin1 inputs with a valid/ready issue handshake. It holds the operands stable for the whole adder evaluation window.

---
 rtl/add_operand_loader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/add_operand_loader.sv
// add_operand_loader
//
// Operand stage in front of the 32-bit ripple adder. It collects eight byte
// beats from a valid/ready stream: beats 0-3 form operand A and beats 4-7
// form operand B. The carry-in is taken on beat 7. The assembled set is then
// offered to the adder through a valid/ready issue handshake, and it is held
// stable until the adder side accepts it.
//
// Parameters:
//   LSB_FIRST  1: the first beat of an operand is byte 0 (bits 7:0)
//              0: the first beat of an operand is byte 3 (bits 31:24)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous abort: flushes the set and clears the operands
//   in_data    operand byte
//   in_cin     carry-in, sampled on the final (8th) beat only
//   in_valid   upstream byte valid
//   in_ready   loader accepts a byte this cycle (low in ISSUE and in reset)
//   out_in1    operand A to the adder in1
//   out_in2    operand B to the adder in2
//   out_cin1   carry-in to the adder cin1
//   out_valid  operand set valid
//   out_ready  downstream consumed the operand set
//   beat_cnt   index of the next beat expected, 0..7
//
// Optional feature, enabled by defining ADD_LDR_PARITY_EN:
//   in_par     odd parity bit for in_data
//   par_err    sticky parity error flag, cleared only by clr or reset.
//              A set that contained a bad beat is discarded, not issued.

module add_operand_loader #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic [7:0]  in_data,
  input  logic        in_cin,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_in1,
  output logic [31:0] out_in2,
  output logic        out_cin1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  beat_cnt
`ifdef ADD_LDR_PARITY_EN
  ,
  input  logic        in_par,
  output logic        par_err
`endif
);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    ISSUE  = 2'd2
  } state_t;

  state_t      state;
  logic        xfer;
  logic [1:0]  lane;
  logic [4:0]  bit_base;
  logic        drop_set;

  // in_ready is a pure decode of state, gated so it is low during reset.
  assign in_ready = rst_n && (state != ISSUE);
  assign xfer     = in_valid && in_ready;

  // Byte lane within the current operand. For MSB-first order the lane
  // is 3-k, and for a 2-bit k that is the bitwise inverse.
  assign lane     = LSB_FIRST ? beat_cnt[1:0] : ~beat_cnt[1:0];
  assign bit_base = {lane, 3'b000};

`ifdef ADD_LDR_PARITY_EN
  logic beat_bad;
  logic set_bad;

  // Odd parity: data plus parity bit must hold an odd number of ones.
  assign beat_bad = ~(^{in_data, in_par});

  // Discard when an earlier beat of this set was bad, or this beat is bad.
  assign drop_set = set_bad || beat_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err <= 1'b0;
      set_bad <= 1'b0;
    end else if (clr) begin
      par_err <= 1'b0;
      set_bad <= 1'b0;
    end else if (xfer) begin
      if (beat_bad) begin
        par_err <= 1'b1;
      end
      // The per-set flag is cleared by the final beat, so the next set
      // starts clean whatever happened to this one.
      if (beat_cnt == 3'd7) begin
        set_bad <= 1'b0;
      end else if (beat_bad) begin
        set_bad <= 1'b1;
      end
    end
  end
`else
  assign drop_set = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD_A;
      beat_cnt  <= '0;
      out_in1   <= '0;
      out_in2   <= '0;
      out_cin1  <= 1'b0;
      out_valid <= 1'b0;
    end else if (clr) begin
      state     <= LOAD_A;
      beat_cnt  <= '0;
      out_in1   <= '0;
      out_in2   <= '0;
      out_cin1  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          if (xfer) begin
            out_in1[bit_base +: 8] <= in_data;
            beat_cnt               <= beat_cnt + 3'd1;
            if (beat_cnt == 3'd3) begin
              state <= LOAD_B;
            end
          end
        end

        LOAD_B: begin
          if (xfer) begin
            out_in2[bit_base +: 8] <= in_data;
            // The 3-bit counter wraps from 7 back to 0 by itself.
            beat_cnt               <= beat_cnt + 3'd1;
            if (beat_cnt == 3'd7) begin
              out_cin1 <= in_cin;
              if (drop_set) begin
                state     <= LOAD_A;
                out_valid <= 1'b0;
              end else begin
                state     <= ISSUE;
                out_valid <= 1'b1;
              end
            end
          end
        end

        ISSUE: begin
          // The operands stay put here. Only the handshake leaves ISSUE.
          if (out_valid && out_ready) begin
            state     <= LOAD_A;
            out_valid <= 1'b0;
          end
        end

        default: begin
          state     <= LOAD_A;
          beat_cnt  <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
